wide_add_sequencer: RTL and testbench

- Multi-cycle WIDTH-bit adder/subtractor built around the team's existing 8-bit carry-lookahead unit.
- Processes one 8-bit slice per cycle, least significant slice first.
- Sits on both sides of the carry unit: it drives that unit's p, g and cin inputs, then consumes the returned c[7:0] to form sum bits and the inter-slice carry.
- Upstream and downstream ALU logic connect through valid/ready handshakes.

---
 rtl/wide_add_sequencer_pkg.sv | 8 +
 rtl/wide_add_sequencer_if.sv | 13 +
 rtl/wide_add_sequencer_slice.sv | 14 +
 rtl/wide_add_sequencer.sv | 91 +++++++++
 tb/tb_wide_add_sequencer.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/wide_add_sequencer_pkg.sv
// alu_pkg: shared ALU types, slice width and the operand-width legality check.
package alu_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int SLICE_W = 8;
   function automatic bit width_ok(int w);
      return w >= SLICE_W && w % SLICE_W == 0;
   endfunction
endpackage

// File: rtl/wide_add_sequencer_if.sv
// wide_add_sequencer_if: operand/result handshake bundle; WADD_ZERO_FLAG_EN adds zero.
interface wide_add_sequencer_if #(parameter int WIDTH = 32);
   logic in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
   logic [WIDTH-1:0] a, b, sum;
`ifdef WADD_ZERO_FLAG_EN
   logic zero;
   modport master (output in_valid, a, b, sub, out_ready, input in_ready, out_valid, sum, cout, ovf, zero);
   modport slave (input in_valid, a, b, sub, out_ready, output in_ready, out_valid, sum, cout, ovf, zero);
`else
   modport master (output in_valid, a, b, sub, out_ready, input in_ready, out_valid, sum, cout, ovf);
   modport slave (input in_valid, a, b, sub, out_ready, output in_ready, out_valid, sum, cout, ovf);
`endif
endinterface

// File: rtl/wide_add_sequencer_slice.sv
// wadd_slice: per-slice propagate/generate and sum from the carries returned by the CLA unit.
module wadd_slice (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   input  logic [7:0] c,
   output logic [7:0] p,
   output logic [7:0] g,
   output logic [7:0] s
);
   assign p = a ^ b;
   assign g = a & b;
   assign s = p ^ {c[6:0], cin};
endmodule

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: WIDTH-bit add/sub, one 8-bit slice per cycle through an external CLA.
// Optional zero flag under macro WADD_ZERO_FLAG_EN.
module wide_add_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   wide_add_sequencer_if.slave  bus,
   output logic [7:0]           cla_p,
   output logic [7:0]           cla_g,
   output logic                 cla_cin,
   input  logic [7:0]           cla_c
);
   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("wide_add_sequencer: WIDTH must be a multiple of 8 and at least 8");
   end
   state_t state;
   logic [WIDTH-1:0] ra, rb;
   logic [IW-1:0] idx;
   logic carry;
   logic [7:0] p, g, ssum;
   logic last;
   assign last = idx == IW'(NSLICE - 1);
   wadd_slice u_slice (
      .a   (ra[{idx, 3'b000} +: 8]),
      .b   (rb[{idx, 3'b000} +: 8]),
      .cin (carry),
      .c   (cla_c),
      .p   (p),
      .g   (g),
      .s   (ssum)
   );
   assign cla_p = state == RUN ? p : '0;
   assign cla_g = state == RUN ? g : '0;
   assign cla_cin = state == RUN ? carry : 1'b0;
   assign bus.in_ready = state == IDLE;
   assign bus.out_valid = state == DONE;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ra <= '0;
         rb <= '0;
         idx <= '0;
         carry <= 1'b0;
         bus.sum <= '0;
         bus.cout <= 1'b0;
         bus.ovf <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               ra <= bus.a;
               rb <= bus.b ^ {WIDTH{bus.sub}};
               carry <= bus.sub;
               idx <= '0;
               state <= RUN;
            end
            RUN: begin
               bus.sum[{idx, 3'b000} +: 8] <= ssum;
               carry <= cla_c[7];
               idx <= idx + 1'b1;
               if (last) begin
                  bus.cout <= cla_c[7];
                  bus.ovf <= cla_c[7] ^ cla_c[6];
                  state <= DONE;
               end
            end
            DONE: if (bus.out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
`ifdef WADD_ZERO_FLAG_EN
   // running AND of slice-is-zero, folded into zero on the last slice
   logic zacc;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zacc <= 1'b0;
         bus.zero <= 1'b0;
      end else if (state == IDLE && bus.in_valid) begin
         zacc <= 1'b1;
      end else if (state == RUN) begin
         zacc <= zacc & ~|ssum;
         if (last) bus.zero <= zacc & ~|ssum;
      end
   end
`endif
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: randomized and directed checks against an arithmetic reference model.
module tb_wide_add_sequencer;
   localparam int W = 32;
   localparam int NS = W / 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] cla_p, cla_g, cla_c;
   logic cla_cin;
   int cmp = 0;
   int errs = 0;
   wide_add_sequencer_if #(.WIDTH(W)) bus ();
   wide_add_sequencer #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .cla_p   (cla_p),
      .cla_g   (cla_g),
      .cla_cin (cla_cin),
      .cla_c   (cla_c)
   );
   always #5 clk = ~clk;
   always_comb begin
      logic cc;
      cla_c = '0;
      cc = cla_cin;
      for (int i = 0; i < 8; i++) begin
         cc = cla_g[i] | (cla_p[i] & cc);
         cla_c[i] = cc;
      end
   end
   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      cmp++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask
   // {ovf, cout, sum} from plain signed/unsigned arithmetic
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      logic [W:0] r;
      logic sx, sy, sr, v;
      r = s ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, y};
      sx = x[W-1];
      sy = y[W-1];
      sr = r[W-1];
      v = s ? (sx != sy && sr != sx) : (sx == sy && sr != sx);
      return {v, s ? ~r[W] : r[W], r[W-1:0]};
   endfunction
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input bit hold);
      logic [W+1:0] e;
      int lat;
      e = model(x, y, s);
      @(negedge clk);
      check("in_ready_before", W'(bus.in_ready), W'(1));
      bus.a = x;
      bus.b = y;
      bus.sub = s;
      bus.in_valid = 1'b1;
      bus.out_ready = !hold;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         if (k > 1 || 1) begin
            @(posedge clk);
            #1;
         end
         if (bus.out_valid) begin
            lat = k;
            break;
         end
      end
      check("latency", W'(lat), W'(NS));
      check("sum", bus.sum, e[W-1:0]);
      check("cout", W'(bus.cout), W'(e[W]));
      check("ovf", W'(bus.ovf), W'(e[W+1]));
`ifdef WADD_ZERO_FLAG_EN
      check("zero", W'(bus.zero), W'(e[W-1:0] == '0));
`endif
      if (hold) begin
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.in_valid = ~bus.in_valid;
            bus.a = $urandom;
            bus.b = $urandom;
            @(posedge clk);
            #1;
            check("hold_valid", W'(bus.out_valid), W'(1));
            check("hold_in_ready", W'(bus.in_ready), W'(0));
            check("hold_sum", bus.sum, e[W-1:0]);
            check("hold_flags", W'({bus.cout, bus.ovf}), W'(e[W+1:W] ^ {e[W+1], e[W]} ^ {e[W], e[W+1]}));
         end
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      check("valid_drop", W'(bus.out_valid), W'(0));
      check("in_ready_after", W'(bus.in_ready), W'(1));
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.sub = 1'b0;
      bus.out_ready = 1'b1;
      #2;
      check("rst_in_ready", W'(bus.in_ready), W'(1));
      check("rst_out_valid", W'(bus.out_valid), W'(0));
      check("rst_sum", bus.sum, '0);
      check("rst_flags", W'({bus.cout, bus.ovf}), W'(0));
      check("rst_cla", W'({cla_p, cla_g, cla_cin}), W'(0));
      @(negedge clk);
      rst = 1'b0;
      run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
      run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
      run_op(32'd5, 32'd7, 1'b1, 0);
      run_op(32'd7, 32'd5, 1'b1, 0);
      run_op(32'h8000_0000, 32'd1, 1'b1, 0);
      run_op($urandom, $urandom, 1'b0, 1);
      for (int n = 0; n < 30; n++) run_op($urandom, $urandom, 1'($urandom), 0);
      run_op(32'd9, 32'd9, 1'b1, 0);
      @(negedge clk);
      bus.a = 32'hDEAD_BEEF;
      bus.b = 32'h1357_9BDF;
      bus.sub = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort_out_valid", W'(bus.out_valid), W'(0));
      check("abort_in_ready", W'(bus.in_ready), W'(1));
      check("abort_sum", bus.sum, '0);
      @(negedge clk);
      rst = 1'b0;
      run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 0);
      check("post_reset_sum", bus.sum, 32'h2345_6789);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end
endmodule
